// File: rtl/sensor_stats_cmd_if.sv
// Sensor sample, UART command and report-request signals shared by the stats block and its peers.
interface sensor_stats_cmd_if;
  logic       sample_valid;
  logic       sample_err;
  logic [7:0] i_temp;
  logic [7:0] i_humi;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       temp_start;
  logic       humi_start;
  logic [7:0] o_max_temp;
  logic [7:0] o_min_temp;
  logic [7:0] o_max_humi;
  logic [7:0] o_min_humi;
  logic       o_have_data;
  logic       o_busy;

  // Producer side: sensor reader, UART receive path and report sender.
  modport master (
    output sample_valid, sample_err, i_temp, i_humi, rx_done, rx_data,
    input  temp_start, humi_start, o_max_temp, o_min_temp, o_max_humi, o_min_humi,
    input  o_have_data, o_busy
  );

  // Stats/command block side.
  modport slave (
    input  sample_valid, sample_err, i_temp, i_humi, rx_done, rx_data,
    output temp_start, humi_start, o_max_temp, o_min_temp, o_max_humi, o_min_humi,
    output o_have_data, o_busy
  );
endinterface

// File: rtl/sensor_stats_cmd.sv
// Running max/min tracker with UART command decode and held-off report requests.
module sensor_stats_cmd #(
  parameter int unsigned HOLDOFF_CYCLES = 3_000_000
) (
  input  logic               clk,
  input  logic               reset,
  sensor_stats_cmd_if.slave  bus
);

  localparam int unsigned CNT_W   = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [7:0]  VAL_MAX = 8'd99;

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  typedef struct packed {
    logic [7:0] max_t;
    logic [7:0] min_t;
    logic [7:0] max_h;
    logic [7:0] min_h;
  } stats_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stats_t           live_q, live_d;
  stats_t           snap_q, snap_d;
  logic             have_q, have_d;
  logic             pend_t_q, pend_t_d;
  logic             pend_h_q, pend_h_d;
  logic             temp_start_q, temp_start_d;
  logic             humi_start_q, humi_start_d;
  logic             busy_q, busy_d;

  logic       cmd_t, cmd_h, cmd_c, good;
  logic [7:0] samp_t, samp_h;

  // Command decode and two-digit clamp of the incoming sample.
  always_comb begin
    cmd_t  = bus.rx_done && ((bus.rx_data == 8'h54) || (bus.rx_data == 8'h74));
    cmd_h  = bus.rx_done && ((bus.rx_data == 8'h48) || (bus.rx_data == 8'h68));
    cmd_c  = bus.rx_done && ((bus.rx_data == 8'h43) || (bus.rx_data == 8'h63));
    good   = bus.sample_valid && !bus.sample_err;
    samp_t = (bus.i_temp > VAL_MAX) ? VAL_MAX : bus.i_temp;
    samp_h = (bus.i_humi > VAL_MAX) ? VAL_MAX : bus.i_humi;
  end

  // Live stats: clear first, so a coincident good sample becomes the first sample.
  always_comb begin
    live_d = live_q;
    have_d = have_q;
    if (cmd_c) begin
      live_d = '0;
      have_d = 1'b0;
    end
    if (good) begin
      if (!have_d) begin
        live_d = '{max_t: samp_t, min_t: samp_t, max_h: samp_h, min_h: samp_h};
      end else begin
        if (samp_t > live_d.max_t) live_d.max_t = samp_t;
        if (samp_t < live_d.min_t) live_d.min_t = samp_t;
        if (samp_h > live_d.max_h) live_d.max_h = samp_h;
        if (samp_h < live_d.min_h) live_d.min_h = samp_h;
      end
      have_d = 1'b1;
    end
  end

  // Request FSM: issue from IDLE (temperature first), then hold off while the report drains.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    temp_start_d = 1'b0;
    humi_start_d = 1'b0;
    pend_t_d     = pend_t_q | cmd_t;
    pend_h_d     = pend_h_q | cmd_h;
    case (state_q)
      S_IDLE: begin
        if (pend_t_q || cmd_t) begin
          temp_start_d = 1'b1;
          pend_t_d     = pend_t_q && cmd_t;
          snap_d       = live_q;
          state_d      = S_HOLD;
          cnt_d        = '0;
        end else if (pend_h_q || cmd_h) begin
          humi_start_d = 1'b1;
          pend_h_d     = pend_h_q && cmd_h;
          snap_d       = live_q;
          state_d      = S_HOLD;
          cnt_d        = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_HOLD);
  end

  // State, stats, snapshot and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      live_q       <= '0;
      snap_q       <= '0;
      have_q       <= 1'b0;
      pend_t_q     <= 1'b0;
      pend_h_q     <= 1'b0;
      temp_start_q <= 1'b0;
      humi_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      live_q       <= live_d;
      snap_q       <= snap_d;
      have_q       <= have_d;
      pend_t_q     <= pend_t_d;
      pend_h_q     <= pend_h_d;
      temp_start_q <= temp_start_d;
      humi_start_q <= humi_start_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.temp_start  = temp_start_q;
  assign bus.humi_start  = humi_start_q;
  assign bus.o_max_temp  = snap_q.max_t;
  assign bus.o_min_temp  = snap_q.min_t;
  assign bus.o_max_humi  = snap_q.max_h;
  assign bus.o_min_humi  = snap_q.min_h;
  assign bus.o_have_data = have_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_sensor_stats_cmd.sv
// Randomized and directed bench for sensor_stats_cmd against a behavioural reference model.
module tb_sensor_stats_cmd;

  localparam int unsigned HOLD = 40;

  logic clk = 1'b0;
  logic reset;
  sensor_stats_cmd_if bus();

  sensor_stats_cmd #(.HOLDOFF_CYCLES(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: index 0 max temp, 1 min temp, 2 max humi, 3 min humi.
  int live[4];
  int snap[4];
  bit m_have, m_pt, m_ph, m_ts, m_hs;
  int m_rem;   // cycles of hold-off still to run after the current one

  always @(posedge clk or posedge reset) begin : model
    int t, h;
    bit good, ct, ch, cc;
    if (reset) begin
      live   = '{0, 0, 0, 0};
      snap   = '{0, 0, 0, 0};
      m_have = 0; m_pt = 0; m_ph = 0; m_ts = 0; m_hs = 0; m_rem = 0;
    end else begin
      good = bus.sample_valid && !bus.sample_err;
      t    = (int'(bus.i_temp) > 99) ? 99 : int'(bus.i_temp);
      h    = (int'(bus.i_humi) > 99) ? 99 : int'(bus.i_humi);
      ct   = bus.rx_done && (bus.rx_data == 8'h54 || bus.rx_data == 8'h74);
      ch   = bus.rx_done && (bus.rx_data == 8'h48 || bus.rx_data == 8'h68);
      cc   = bus.rx_done && (bus.rx_data == 8'h43 || bus.rx_data == 8'h63);
      m_ts = 0;
      m_hs = 0;
      // A request is consumed by the issue; a command landing in the same cycle
      // re-arms an already-raised flag, otherwise the command itself is what issued.
      if (m_rem > 0) begin
        m_rem--;
      end else if (m_pt || ct) begin
        m_ts = 1; snap = live; m_rem = HOLD;
        if (m_pt) m_pt = ct;
        ct = 0;
      end else if (m_ph || ch) begin
        m_hs = 1; snap = live; m_rem = HOLD;
        if (m_ph) m_ph = ch;
        ch = 0;
      end
      m_pt = m_pt || ct;
      m_ph = m_ph || ch;
      if (cc) begin
        live   = '{0, 0, 0, 0};
        m_have = 0;
      end
      if (good) begin
        if (!m_have) live = '{t, t, h, h};
        else begin
          if (t > live[0]) live[0] = t;
          if (t < live[1]) live[1] = t;
          if (h > live[2]) live[2] = h;
          if (h < live[3]) live[3] = h;
        end
        m_have = 1;
      end
    end
  end

  // Every-cycle comparison against the model, plus pulse bookkeeping.
  int cyc = 0;
  int n_tp = 0, n_hp = 0, last_tp = 0, last_hp = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    check("temp_start", int'(bus.temp_start), int'(m_ts));
    check("humi_start", int'(bus.humi_start), int'(m_hs));
    check("max_temp",   int'(bus.o_max_temp), snap[0]);
    check("min_temp",   int'(bus.o_min_temp), snap[1]);
    check("max_humi",   int'(bus.o_max_humi), snap[2]);
    check("min_humi",   int'(bus.o_min_humi), snap[3]);
    check("have_data",  int'(bus.o_have_data), int'(m_have));
    check("busy",       int'(bus.o_busy), int'(m_rem > 0));
    if (bus.temp_start) begin n_tp++; last_tp = cyc; end
    if (bus.humi_start) begin n_hp++; last_hp = cyc; end
  end

  task automatic drive(input bit sv, input bit se, input logic [7:0] t, input logic [7:0] h,
                       input bit rd, input logic [7:0] d);
    bus.sample_valid = sv;
    bus.sample_err   = se;
    bus.i_temp       = t;
    bus.i_humi       = h;
    bus.rx_done      = rd;
    bus.rx_data      = d;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.sample_err   = 1'b0;
    bus.rx_done      = 1'b0;
  endtask

  task automatic send_sample(input logic [7:0] t, input logic [7:0] h, input bit err);
    drive(1'b1, err, t, h, 1'b0, 8'h00);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, b);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_rem != 0 || m_pt || m_ph) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", k, (m_rem != 0 || m_pt || m_ph) ? -1 : k);
    @(negedge clk);
  endtask

  task automatic wait_pulse(input bit humi, input int prev);
    int k = 0;
    while (((humi ? n_hp : n_tp) == prev) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(humi ? "humi_timeout" : "temp_timeout", humi ? n_hp : n_tp, prev + 1);
  endtask

  task automatic check_snap(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_maxt"}, int'(bus.o_max_temp), a);
    check({tag, "_mint"}, int'(bus.o_min_temp), b);
    check({tag, "_maxh"}, int'(bus.o_max_humi), c);
    check({tag, "_minh"}, int'(bus.o_min_humi), d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, prev;
    logic [7:0] cmds [8];
    cmds = '{8'h54, 8'h74, 8'h48, 8'h68, 8'h43, 8'h63, 8'h41, 8'h00};
    reset = 1'b1;
    bus.sample_valid = 1'b0; bus.sample_err = 1'b0; bus.i_temp = '0; bus.i_humi = '0;
    bus.rx_done = 1'b0; bus.rx_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_have", int'(bus.o_have_data), 0);
    check("rst_tstart", int'(bus.temp_start), 0);
    check_snap("rst", 0, 0, 0, 0);

    // Errored sample before any good one leaves have_data low.
    send_sample(8'd5, 8'd5, 1'b1);
    check("err_first_have", int'(bus.o_have_data), 0);

    // Stats, clamp and error discard.
    send_sample(8'd25, 8'd60, 1'b0);
    send_sample(8'd31, 8'd55, 1'b0);
    send_sample(8'd120, 8'd40, 1'b0);
    send_sample(8'd5, 8'd5, 1'b1);
    check("s1_have", int'(bus.o_have_data), 1);
    prev = n_tp;
    send_cmd(8'h54);
    check("s1_tstart", int'(bus.temp_start), 1);
    check("s1_busy", int'(bus.o_busy), 1);
    check_snap("s1", 99, 25, 60, 40);
    t0 = last_tp;

    // Priority and queueing: H then T while held off.
    send_cmd(8'h48);
    send_cmd(8'h54);
    wait_pulse(1'b0, prev + 1);
    check("s3_t_spacing", last_tp - t0, HOLD + 1);
    wait_pulse(1'b1, 0);
    check("s3_h_spacing", last_hp - last_tp, HOLD + 1);
    prev = n_tp;
    send_cmd(8'h54);
    repeat (3) @(negedge clk);
    send_cmd(8'h74);
    repeat (130) @(negedge clk);
    check("s3_extra_t", n_tp - prev, 1);
    check_snap("s3", 99, 25, 60, 40);

    // Snapshot stays frozen through a sample taken during hold-off.
    wait_idle();
    send_cmd(8'h74);
    check("s4_tstart", int'(bus.temp_start), 1);
    send_sample(8'd10, 8'd90, 1'b0);
    check_snap("s4_hold", 99, 25, 60, 40);
    prev = n_hp;
    send_cmd(8'h68);
    wait_pulse(1'b1, prev);
    check_snap("s4_next", 99, 10, 90, 40);

    // Clear and sample in the same cycle.
    wait_idle();
    drive(1'b1, 1'b0, 8'd18, 8'd33, 1'b1, 8'h43);
    check("s5_have", int'(bus.o_have_data), 1);
    send_cmd(8'h54);
    check("s5_tstart", int'(bus.temp_start), 1);
    check_snap("s5", 18, 18, 33, 33);

    // Reset in the middle of hold-off.
    wait_idle();
    send_cmd(8'h54);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("s6_busy", int'(bus.o_busy), 0);
    check("s6_have", int'(bus.o_have_data), 0);
    check_snap("s6_rst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("s6_no_pulse", int'(bus.temp_start), 0);
    send_cmd(8'h54);
    check("s6_tstart", int'(bus.temp_start), 1);
    check_snap("s6", 0, 0, 0, 0);

    // Random traffic; the every-cycle model comparison does the checking.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              $urandom_range(0, 9) == 0,
              ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : cmds[$urandom_range(0, 7)]);
      end
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
